// File: rtl/opnd_fwd_if.sv
// Operand-resolution bundle between ID-side drivers and the ID/EX register.
// Inputs flow master -> slave; registered operands and stall info flow back.
interface opnd_fwd_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    logic                        id_valid_i;
    logic [NUM_RD-1:0]           rd_en_i;
    logic [NUM_RD*ADDR_W-1:0]    rd_addr_i;
    logic [NUM_RD*DATA_W-1:0]    rf_data_i;
    logic [DATA_W-1:0]           imm_i;
    logic [NUM_FWD-1:0]          fwd_wreg_i;
    logic [NUM_FWD*ADDR_W-1:0]   fwd_wd_i;
    logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i;
    logic [NUM_FWD-1:0]          fwd_pend_i;
    logic                        ex_stall_i;
    logic [NUM_RD*DATA_W-1:0]    opnd_o;
    logic                        ex_valid_o;
    logic                        stallreq_o;
    logic [CNT_W-1:0]            stall_cnt_o;

    modport master (
        output id_valid_i, rd_en_i, rd_addr_i, rf_data_i, imm_i,
        output fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pend_i, ex_stall_i,
        input  opnd_o, ex_valid_o, stallreq_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, rd_en_i, rd_addr_i, rf_data_i, imm_i,
        input  fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pend_i, ex_stall_i,
        output opnd_o, ex_valid_o, stallreq_o, stall_cnt_o
    );
endinterface

// File: rtl/opnd_fwd_reg.sv
// Operand resolution with multi-stage forwarding, load-use stall detection
// and the ID/EX operand register.
module opnd_fwd_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input logic       clk,
    input logic       rst,
    opnd_fwd_if.slave bus
);
    logic [NUM_RD*DATA_W-1:0] res;
    logic [NUM_RD-1:0]        port_haz;
    logic [NUM_RD-1:0]        hit;
    logic                     hazard;

    logic [NUM_RD*DATA_W-1:0] opnd_q, opnd_d;
    logic                     valid_q, valid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    // Youngest matching source (lowest j) decides; older ones are ignored.
    always_comb begin
        res      = '0;
        port_haz = '0;
        hit      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!bus.rd_en_i[k]) begin
                res[k*DATA_W +: DATA_W] = bus.imm_i;
            end else if (bus.rd_addr_i[k*ADDR_W +: ADDR_W] == '0) begin
                res[k*DATA_W +: DATA_W] = '0;
            end else begin
                res[k*DATA_W +: DATA_W] = bus.rf_data_i[k*DATA_W +: DATA_W];
                for (int j = 0; j < NUM_FWD; j++) begin
                    if (!hit[k] && bus.fwd_wreg_i[j] &&
                        bus.fwd_wd_i[j*ADDR_W +: ADDR_W] ==
                        bus.rd_addr_i[k*ADDR_W +: ADDR_W]) begin
                        hit[k] = 1'b1;
                        if (bus.fwd_pend_i[j]) begin
                            port_haz[k] = 1'b1;
                        end else begin
                            res[k*DATA_W +: DATA_W] =
                                bus.fwd_wdata_i[j*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
    end

    assign hazard = bus.id_valid_i & (|port_haz);

    // A downstream hold outranks the bubble; the counter runs regardless.
    always_comb begin
        opnd_d  = opnd_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!bus.ex_stall_i) begin
            if (hazard) begin
                opnd_d  = '0;
                valid_d = 1'b0;
            end else begin
                opnd_d  = res;
                valid_d = bus.id_valid_i;
            end
        end
        if (hazard && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            opnd_q  <= opnd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.opnd_o      = opnd_q;
    assign bus.ex_valid_o  = valid_q;
    assign bus.stallreq_o  = hazard;
    assign bus.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_opnd_fwd_reg.sv
// Scoreboard bench for opnd_fwd_reg: directed scenarios plus random traffic
// checked against a behavioural operand/stall model.
module tb_opnd_fwd_reg;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NF   = 2;
    localparam int CW   = 12;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [NR*DW-1:0] op;
        logic             v;
        int               c;
    } exp_t;

    logic clk;
    logic rst;

    opnd_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
                  .NUM_FWD(NF), .CNT_W(CW)) bus ();

    opnd_fwd_reg #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
                   .NUM_FWD(NF), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit          en  [NR];
    logic [AW-1:0] ad [NR];
    logic [DW-1:0] rf [NR];
    logic [DW-1:0] imm;
    bit          fw  [NF];
    logic [AW-1:0] fa [NF];
    logic [DW-1:0] fd [NF];
    bit          fp  [NF];
    bit          idv, exs, rst_r;

    logic [NR*DW-1:0] m_op;
    bit               m_v;
    int               m_c;
    exp_t             sb[$];
    exp_t             mon_e;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: list all matching sources, the first listed is the youngest.
    function automatic void resolve(output logic [NR*DW-1:0] r, output bit h);
        int m[$];
        logic [DW-1:0] v;
        r = '0;
        h = 1'b0;
        for (int k = 0; k < NR; k++) begin
            m.delete();
            if (!en[k]) v = imm;
            else if (ad[k] == 0) v = '0;
            else begin
                for (int j = 0; j < NF; j++)
                    if (fw[j] && fa[j] == ad[k]) m.push_back(j);
                if (m.size() == 0) v = rf[k];
                else if (fp[m[0]]) begin
                    h = 1'b1;
                    v = rf[k];
                end else v = fd[m[0]];
            end
            r[k*DW +: DW] = v;
        end
    endfunction

    task automatic drive();
        rst = rst_r;
        bus.id_valid_i = idv;
        bus.ex_stall_i = exs;
        bus.imm_i = imm;
        for (int k = 0; k < NR; k++) begin
            bus.rd_en_i[k] = en[k];
            bus.rd_addr_i[k*AW +: AW] = ad[k];
            bus.rf_data_i[k*DW +: DW] = rf[k];
        end
        for (int j = 0; j < NF; j++) begin
            bus.fwd_wreg_i[j] = fw[j];
            bus.fwd_wd_i[j*AW +: AW] = fa[j];
            bus.fwd_wdata_i[j*DW +: DW] = fd[j];
            bus.fwd_pend_i[j] = fp[j];
        end
    endtask

    task automatic cyc();
        logic [NR*DW-1:0] r;
        bit haz;
        exp_t e;
        drive();
        #1;
        resolve(r, haz);
        haz = haz && idv;
        chk("stallreq", 64'(bus.stallreq_o), 64'(haz));
        if (rst_r) begin
            m_op = '0;
            m_v  = 1'b0;
            m_c  = 0;
        end else begin
            if (haz && m_c < CMAX) m_c = m_c + 1;
            if (!exs) begin
                m_op = haz ? '0 : r;
                m_v  = haz ? 1'b0 : idv;
            end
        end
        e.op = m_op;
        e.v  = m_v;
        e.c  = m_c;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic defaults();
        for (int k = 0; k < NR; k++) begin
            en[k] = 1'b1;
            ad[k] = AW'(10 + k);
            rf[k] = 32'h1000 + k;
        end
        for (int j = 0; j < NF; j++) begin
            fw[j] = 1'b0;
            fa[j] = '0;
            fd[j] = '0;
            fp[j] = 1'b0;
        end
        imm = '0;
        idv = 1'b1;
        exs = 1'b0;
        rst_r = 1'b0;
    endtask

    task automatic rnd_inputs();
        for (int k = 0; k < NR; k++) begin
            en[k] = ($urandom_range(0, 4) != 0);
            ad[k] = AW'($urandom_range(0, 3));
            rf[k] = $urandom;
        end
        for (int j = 0; j < NF; j++) begin
            fw[j] = $urandom_range(0, 1) == 1;
            fa[j] = AW'($urandom_range(0, 3));
            fd[j] = $urandom;
            fp[j] = ($urandom_range(0, 3) == 0);
        end
        imm = $urandom;
        idv = ($urandom_range(0, 4) != 0);
    endtask

    // Monitor: every registered update is checked against the queued model.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("opnd_o", 64'(bus.opnd_o), 64'(mon_e.op));
            chk("ex_valid_o", 64'(bus.ex_valid_o), 64'(mon_e.v));
            chk("stall_cnt_o", 64'(bus.stall_cnt_o), 64'(mon_e.c));
        end
    end

    logic [NR*DW-1:0] hold_op;
    logic             hold_v;

    initial begin
        defaults();
        rst_r = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        chk("reset_opnd", 64'(bus.opnd_o), 64'h0);
        chk("reset_cnt", 64'(bus.stall_cnt_o), 64'h0);
        rst_r = 1'b0;

        ad[0] = 5'd3;  rf[0] = 32'h33;
        fw[0] = 1'b1;  fa[0] = 5'd3;  fd[0] = 32'h11;
        fw[1] = 1'b1;  fa[1] = 5'd3;  fd[1] = 32'h22;
        cyc();
        chk("alu_fwd_opnd0", 64'(bus.opnd_o[DW-1:0]), 64'h11);
        chk("alu_fwd_valid", 64'(bus.ex_valid_o), 64'h1);

        ad[1] = 5'd0;  rf[1] = 32'h55;
        fa[0] = 5'd0;  fd[0] = 32'hDEAD;  fp[0] = 1'b1;
        cyc();
        chk("zero_reg_stall", 64'(bus.stallreq_o), 64'h0);
        chk("zero_reg_opnd1", 64'(bus.opnd_o[2*DW-1:DW]), 64'h0);

        fp[0] = 1'b0;  fa[0] = 5'd7;  fd[0] = 32'h77;
        fw[1] = 1'b1;  fa[1] = 5'd7;  fp[1] = 1'b1;
        ad[0] = 5'd7;
        cyc();
        chk("hidden_old_stall", 64'(bus.stallreq_o), 64'h0);
        chk("hidden_old_opnd0", 64'(bus.opnd_o[DW-1:0]), 64'h77);

        fw[1] = 1'b0;  fp[1] = 1'b0;
        fw[0] = 1'b1;  fa[0] = 5'd5;  fp[0] = 1'b1;  fd[0] = 32'h0;
        ad[0] = 5'd5;
        cyc();
        chk("loaduse_stall", 64'(bus.stallreq_o), 64'h1);
        chk("loaduse_bubble_v", 64'(bus.ex_valid_o), 64'h0);
        chk("loaduse_bubble_op", 64'(bus.opnd_o), 64'h0);
        fp[0] = 1'b0;  fd[0] = 32'h1234;
        cyc();
        chk("loaduse_opnd0", 64'(bus.opnd_o[DW-1:0]), 64'h1234);
        chk("loaduse_valid", 64'(bus.ex_valid_o), 64'h1);
        chk("loaduse_cnt", 64'(bus.stall_cnt_o), 64'h1);

        defaults();
        en[0] = 1'b0;  imm = 32'hABCD;
        cyc();
        chk("imm_opnd0", 64'(bus.opnd_o[DW-1:0]), 64'hABCD);
        hold_op = bus.opnd_o;
        hold_v  = bus.ex_valid_o;
        for (int i = 0; i < 3; i++) begin
            rnd_inputs();
            exs = 1'b1;
            cyc();
            chk("hold_opnd", 64'(bus.opnd_o), 64'(hold_op));
            chk("hold_valid", 64'(bus.ex_valid_o), 64'(hold_v));
        end

        defaults();
        fw[0] = 1'b1;  fa[0] = 5'd10;  fp[0] = 1'b1;
        for (int i = 0; i < (1 << CW) + 5; i++) cyc();
        chk("cnt_saturate", 64'(bus.stall_cnt_o), 64'(CMAX));

        rst_r = 1'b1;
        cyc();
        rst_r = 1'b0;
        chk("rst_mid_opnd", 64'(bus.opnd_o), 64'h0);
        chk("rst_mid_valid", 64'(bus.ex_valid_o), 64'h0);
        chk("rst_mid_cnt", 64'(bus.stall_cnt_o), 64'h0);

        for (int i = 0; i < 600; i++) begin
            rnd_inputs();
            exs   = ($urandom_range(0, 4) == 0);
            rst_r = ($urandom_range(0, 49) == 0);
            cyc();
        end
        rst_r = 1'b0;

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
